// File: rtl/key_loader_if.sv
// Key provisioning interface: serial frame input and verified key bus output.
//   master : provisioning side, drives load_start/sdi/sdi_valid and observes status
//   slave  : key_loader, consumes the serial frame and drives key/status
interface key_loader_if #(
    parameter int unsigned KEY_WIDTH = 28,
    parameter int unsigned CNT_W     = 4
);
    logic                 load_start;
    logic                 sdi;
    logic                 sdi_valid;
    logic [KEY_WIDTH-1:0] key_out;
    logic                 key_valid;
    logic                 busy;
    logic                 key_err;
    logic [CNT_W-1:0]     fail_cnt;
    logic                 lockout;

    modport master (
        output load_start, sdi, sdi_valid,
        input  key_out, key_valid, busy, key_err, fail_cnt, lockout
    );

    modport slave (
        input  load_start, sdi, sdi_valid,
        output key_out, key_valid, busy, key_err, fail_cnt, lockout
    );
endinterface

// File: rtl/key_loader.sv
// Serial logic-locking key loader. Shifts in a KEY_WIDTH+4 bit frame (MSB first),
// verifies the low nibble against the XOR of all key nibbles and only then
// presents the key; otherwise the key bus stays all-zero.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : key_loader_if.slave (load_start, sdi, sdi_valid in;
//          key_out, key_valid, busy, key_err, fail_cnt, lockout out, all registered)
// Optional feature: define KEY_LOADER_LOCKOUT_EN to enter an absorbing LOCKOUT
// state once fail_cnt reaches MAX_FAIL; otherwise lockout is tied low.
module key_loader #(
    parameter int unsigned KEY_WIDTH = 28,
    parameter int unsigned MAX_FAIL  = 3,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    key_loader_if.slave bus
);
    localparam int unsigned FRAME_W = KEY_WIDTH + 4;
    localparam int unsigned BIT_W   = $clog2(FRAME_W);
    localparam int unsigned NIBBLES = KEY_WIDTH / 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2
`ifdef KEY_LOADER_LOCKOUT_EN
        ,
        LOCKOUT = 2'd3
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]     cnt_q, cnt_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     fail_q, fail_d;
    logic [CNT_W-1:0]     fail_inc;
    logic [3:0]           calc_chk;
    logic                 chk_ok;
`ifdef KEY_LOADER_LOCKOUT_EN
    logic                 lockout_q, lockout_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            key_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            fail_q    <= '0;
`ifdef KEY_LOADER_LOCKOUT_EN
            lockout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
`ifdef KEY_LOADER_LOCKOUT_EN
            lockout_q <= lockout_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        err_d     = err_q;
        fail_d    = fail_q;
`ifdef KEY_LOADER_LOCKOUT_EN
        lockout_d = lockout_q;
`endif

        // Check code: XOR of every key nibble held in the upper frame bits
        calc_chk = 4'd0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            calc_chk = calc_chk ^ shift_q[4 + 4*i +: 4];
        end
        chk_ok   = (calc_chk == shift_q[3:0]);
        fail_inc = (fail_q < CNT_W'(MAX_FAIL)) ? fail_q + CNT_W'(1) : fail_q;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                // sdi is deliberately not sampled in the load_start cycle
                if (bus.load_start) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                    key_d   = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (bus.sdi_valid) begin
                    shift_d = {shift_q[FRAME_W-2:0], bus.sdi};
                    cnt_d   = cnt_q + BIT_W'(1);
                    if (cnt_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (chk_ok) begin
                    key_d   = shift_q[FRAME_W-1:4];
                    valid_d = 1'b1;
                    fail_d  = '0;
                end else begin
                    err_d  = 1'b1;
                    fail_d = fail_inc;
`ifdef KEY_LOADER_LOCKOUT_EN
                    if (fail_inc == CNT_W'(MAX_FAIL)) begin
                        state_d   = LOCKOUT;
                        lockout_d = 1'b1;
                    end
`endif
                end
            end
`ifdef KEY_LOADER_LOCKOUT_EN
            LOCKOUT: begin
                key_d     = '0;
                valid_d   = 1'b0;
                busy_d    = 1'b0;
                lockout_d = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_out   = key_q;
    assign bus.key_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.key_err   = err_q;
    assign bus.fail_cnt  = fail_q;
`ifdef KEY_LOADER_LOCKOUT_EN
    assign bus.lockout   = lockout_q;
`else
    assign bus.lockout   = 1'b0;
`endif

endmodule
